mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares main_memory between I-cache and D-cache miss/store traffic for the rv32im pipelined CPU.
//  Arbitrates requesters, then sequences main_memory's address/RWMode/hit pins to obtain a
//  16-word line (read) or a one-word store (write). Sits between the caches and main_memory.
// PARAMETERS
//  ADDR_W       32   word address width
//  DATA_W       32   store word width
//  LINE_W       512  refill line width (16 x 32)
//  OFFSET_BITS  4    line offset bits; read addresses are forced to addr[OFFSET_BITS-1:0]=0
//  READ_LAT     1    cycles (>=1) after issue before mem_dataOut is sampled
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  i_req        in   1       I-cache line read request, held until i_ack
//  i_addr       in   ADDR_W  I-cache miss word address
//  i_ack        out  1       1-cycle pulse; i_line valid this cycle
//  i_line       out  LINE_W  returned line, held until next I grant
//  d_req        in   1       D-cache request, held until d_ack
//  d_we         in   1       1 = word store, 0 = line read
//  d_addr       in   ADDR_W  D-cache word address
//  d_wdata      in   DATA_W  store data
//  d_ack        out  1       1-cycle pulse; read: d_line valid; write: store committed
//  d_line       out  LINE_W  returned line, held until next D read grant
//  mem_address  out  ADDR_W  to main_memory.address
//  mem_dataIn   out  DATA_W  to main_memory.dataIn
//  mem_RWMode   out  1       to main_memory.RWMode (store on its rising edge)
//  mem_hit      out  1       to main_memory.hit; 0 only while a read is in flight
//  mem_busy     in   1       from main_memory.busy; ISSUE stalls while 1
//  mem_dataOut  in   LINE_W  from main_memory.dataOut
// BEHAVIOUR
//  - Reset values: i_ack=d_ack=0, i_line=d_line=0, mem_address=0, mem_dataIn=0,
//    mem_RWMode=0, mem_hit=1, state=IDLE, wait counter=0, last-grant=D.
//  - FSM: IDLE -> RD_ISSUE -> RD_WAIT -> RESP -> IDLE (read);
//         IDLE -> WR_PULSE -> WR_RECOV -> RESP -> IDLE (write).
//  - IDLE: samples i_req/d_req, picks one winner, latches owner/address/we/wdata; no req = stay.
//  - RD_ISSUE: mem_address={addr[ADDR_W-1:OFFSET_BITS],0}, mem_hit=0, RWMode=0; holds while
//    mem_busy=1; otherwise -> RD_WAIT with counter=READ_LAT.
//  - RD_WAIT: mem_hit stays 0; counter decrements; at 1 latch mem_dataOut into owner's line reg.
//  - WR_PULSE: mem_address=d_addr (not aligned), mem_dataIn=d_wdata, RWMode=1 for exactly 1 cycle.
//  - WR_RECOV: RWMode=0 for at least 1 cycle, so every store yields a fresh rising edge.
//  - RESP: owner's ack=1 for 1 cycle, mem_hit=1. Mandatory IDLE cycle follows, so acks are
//    never back-to-back.
//  - Latency from req seen in IDLE (cycle 0), mem_busy=0: read ack at cycle 2+READ_LAT;
//    write ack at cycle 3.
//  - Request inputs are ignored outside IDLE. Dropping req mid-transaction does not abort it;
//    the ack still pulses.
//  - Ordering: transactions are strictly serial. A read granted after a store observes that store.
//  - Reset mid-operation: abort immediately to reset values. No ack. RWMode returns to 0.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. On simultaneous i_req & d_req, the grant goes to the
//    requester not granted last; last-grant updates on every grant.
//  Undefined: fixed priority, D-cache always wins a tie (I-cache may starve under continuous d_req).
// STRUCTURE
//  Package mem_arb_pkg: state encoding, LINE_WORDS=16, OWNER_I/OWNER_D codes, default widths.
//  Sub-module arb_pick: combinational 2-way picker (fixed/round-robin) plus last-grant flop.
//  The rest is the FSM, wait counter and line registers in mem_arbiter.
// TESTING
//  1 i_req, i_addr=0x25, READ_LAT=1 -> mem_address=0x20 with mem_hit=0; i_ack at cycle 3;
//    i_line=words 0x20..0x2F.
//  2 d_req, d_we=1, d_addr=0x7, d_wdata=0xDEADBEEF -> 1-cycle RWMode pulse, d_ack at cycle 3;
//    following read of 0x0 returns word7=0xDEADBEEF.
//  3 i_req & d_req in the same cycle, both held -> fixed: D,I,D...;
//    MEM_ARB_RR_EN: alternates I/D by last grant, both served in order.
//  4 Two back-to-back stores, d_req held -> RWMode shows 0 between pulses; both words written.
//  5 mem_busy=1 for 4 cycles during RD_ISSUE -> state held, ack delayed by exactly 4 cycles.
//  6 reset asserted in RD_WAIT -> next cycle all outputs at reset values, no ack;
//    a later i_req completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, owner codes and default widths for mem_arbiter
package mem_arb_pkg;
    localparam int LINE_WORDS      = 16;
    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int LINE_W_DEF      = LINE_WORDS * DATA_W_DEF;
    localparam int OFFSET_BITS_DEF = 4;
    localparam int READ_LAT_DEF    = 1;
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_PULSE,
        ST_WR_RECOV,
        ST_RESP
    } state_t;
endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational I/D picker; round-robin on ties when MEM_ARB_RR_EN is defined, else D wins
//   clk, reset  : clock and sync active-high reset (round-robin build only)
//   en_i        : a grant is taken this cycle (round-robin build only)
//   i_req_i     : I-cache request
//   d_req_i     : D-cache request
//   owner_o     : winner, OWNER_I or OWNER_D
module arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic en_i,
`endif
    input  logic i_req_i,
    input  logic d_req_i,
    output logic owner_o
);
`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;
    // on a tie the requester not granted last wins
    always_comb owner_o = (i_req_i && d_req_i) ? ((last_q == OWNER_D) ? OWNER_I : OWNER_D)
                                               : (d_req_i ? OWNER_D : OWNER_I);
    always_comb last_d = (en_i && (i_req_i || d_req_i)) ? owner_o : last_q;
    always_ff @(posedge clk) last_q <= reset ? OWNER_D : last_d;
`else
    // fixed priority needs no history
    always_comb owner_o = d_req_i ? OWNER_D : OWNER_I;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main_memory between I-cache line reads and D-cache line reads / word stores
//   Build option MEM_ARB_RR_EN: round-robin tie-break (default: D-cache wins ties).
//   clk, reset          : clock, synchronous active-high reset
//   i_req/i_addr        : I-cache line read request (held until i_ack)
//   i_ack/i_line        : 1-cycle completion pulse, returned line (held)
//   d_req/d_we/d_addr/d_wdata : D-cache request; d_we=1 word store, 0 line read
//   d_ack/d_line        : 1-cycle completion pulse, returned line (held)
//   mem_address/mem_dataIn/mem_RWMode/mem_hit : drive main_memory
//   mem_busy/mem_dataOut: from main_memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LINE_W      = LINE_W_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF,
    parameter int READ_LAT    = READ_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_line,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_line,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    output logic              mem_RWMode,
    output logic              mem_hit,
    input  logic              mem_busy,
    input  logic [LINE_W-1:0] mem_dataOut
);
    localparam int CNT_W = $clog2(READ_LAT + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFFSET_BITS;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_line_q, i_line_d, d_line_q, d_line_d;
    logic              pick, grant_we;

    arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q == ST_IDLE),
`endif
        .i_req_i (i_req),
        .d_req_i (d_req),
        .owner_o (pick)
    );

    assign grant_we = (pick == OWNER_D) && d_we;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        i_line_d = i_line_q;
        d_line_d = d_line_q;
        case (state_q)
            ST_IDLE: if (i_req || d_req) begin
                owner_d = pick;
                // reads fetch the whole line, stores hit the exact word
                addr_d  = ((pick == OWNER_D) ? d_addr : i_addr) & (grant_we ? {ADDR_W{1'b1}} : ALIGN_MASK);
                wdata_d = grant_we ? d_wdata : wdata_q;
                state_d = grant_we ? ST_WR_PULSE : ST_RD_ISSUE;
            end
            ST_RD_ISSUE: if (!mem_busy) begin
                cnt_d   = CNT_W'(READ_LAT);
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    i_line_d = (owner_q == OWNER_I) ? mem_dataOut : i_line_q;
                    d_line_d = (owner_q == OWNER_D) ? mem_dataOut : d_line_q;
                    state_d  = ST_RESP;
                end
            end
            // recovery cycle guarantees a fresh RWMode rising edge for the next store
            ST_WR_PULSE: state_d = ST_WR_RECOV;
            ST_WR_RECOV: state_d = ST_RESP;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owner_q  <= OWNER_D;
            addr_q   <= '0;
            wdata_q  <= '0;
            i_line_q <= '0;
            d_line_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            i_line_q <= i_line_d;
            d_line_q <= d_line_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_dataIn  = wdata_q;
    assign mem_RWMode  = state_q == ST_WR_PULSE;
    assign mem_hit     = !(state_q == ST_RD_ISSUE || state_q == ST_RD_WAIT);
    assign i_ack       = (state_q == ST_RESP) && (owner_q == OWNER_I);
    assign d_ack       = (state_q == ST_RESP) && (owner_q == OWNER_D);
    assign i_line      = i_line_q;
    assign d_line      = d_line_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural main_memory
module tb_mem_arbiter;
    localparam int RL = 1;

    logic         clk = 1'b0, reset = 1'b1;
    logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_busy = 1'b0;
    logic [31:0]  i_addr = '0, d_addr = '0, d_wdata = '0;
    logic         i_ack, d_ack, mem_RWMode, mem_hit;
    logic [511:0] i_line, d_line, mem_dataOut;
    logic [31:0]  mem_address, mem_dataIn;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_line(i_line),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_line(d_line),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn),
        .mem_RWMode(mem_RWMode), .mem_hit(mem_hit),
        .mem_busy(mem_busy), .mem_dataOut(mem_dataOut)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        mem_init = 1'b1;
    logic        rw_prev = 1'b0;
    int          store_cnt = 0;

    always @(posedge clk) begin
        rw_prev <= mem_RWMode;
        if (mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'hA500_0000 | k;
        end else if (mem_RWMode && !rw_prev) begin
            mem[mem_address[7:0]] <= mem_dataIn;
            store_cnt <= store_cnt + 1;
        end
    end

    always_comb begin
        mem_dataOut = '0;
        for (int k = 0; k < 16; k++) mem_dataOut[k*32 +: 32] = mem[{mem_address[7:4], 4'(k)}];
    end

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic         owner;
        logic         is_rd;
        logic [511:0] line;
    } exp_t;
    exp_t sb[$];
    logic last_d_tb = 1'b1;

    function automatic logic [511:0] ref_line(input logic [31:0] a);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = ref_mem[{a[7:4], 4'(k)}];
        return r;
    endfunction

    task automatic push_rd(input logic own, input logic [31:0] a);
        exp_t e;
        e.owner = own; e.is_rd = 1'b1; e.line = ref_line(a);
        sb.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] w);
        exp_t e;
        ref_mem[a[7:0]] = w;
        e.owner = 1'b1; e.is_rd = 1'b0; e.line = '0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && (i_ack || d_ack)) begin
            exp_t e;
            check("ack_excl", i_ack & d_ack, 0);
            if (sb.size() == 0) check("unexp_ack", {i_ack, d_ack}, 0);
            else begin
                e = sb.pop_front();
                check("ack_owner", d_ack, e.owner);
                if (e.is_rd) check("ack_line", e.owner ? d_line : i_line, e.line);
            end
        end
    end

    task automatic chk_reset(input string p);
        check({p, "_iack"}, i_ack, 0);
        check({p, "_dack"}, d_ack, 0);
        check({p, "_iline"}, i_line, 0);
        check({p, "_dline"}, d_line, 0);
        check({p, "_addr"}, mem_address, 0);
        check({p, "_din"}, mem_dataIn, 0);
        check({p, "_rw"}, mem_RWMode, 0);
        check({p, "_hit"}, mem_hit, 1);
    endtask

    task automatic txn(input logic is_d, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input int busy, output int lat, output logic [31:0] a1, output logic [31:0] w1,
                       output logic h1, output logic rw1, output logic rw2);
        if (we) push_wr(addr, wd); else push_rd(is_d, addr);
        @(negedge clk);
        if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; end
        else begin i_req = 1'b1; i_addr = addr; end
        mem_busy = busy > 0;
        lat = -1; a1 = '0; w1 = '0; h1 = 1'b1; rw1 = 1'b0; rw2 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin a1 = mem_address; w1 = mem_dataIn; h1 = mem_hit; rw1 = mem_RWMode; end
            if (c == 2) rw2 = mem_RWMode;
            if (c == 1 + busy) mem_busy = 1'b0;
            if (is_d ? d_ack : i_ack) begin lat = c; break; end
        end
        i_req = 1'b0; d_req = 1'b0; mem_busy = 1'b0;
        last_d_tb = is_d;
    endtask

    initial begin
        int lat, s0, n;
        int ca[2];
        logic [31:0] a1, w1;
        logic h1, rw1, rw2, first;
        for (int k = 0; k < 256; k++) ref_mem[k] = 32'hA500_0000 | k;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0; mem_init = 1'b0;

        // single I-cache line read
        txn(1'b0, 1'b0, 32'h25, 32'h0, 0, lat, a1, w1, h1, rw1, rw2);
        check("t1_lat", lat, 2 + RL);
        check("t1_addr", a1, 32'h20);
        check("t1_hit", h1, 0);
        check("t1_rw", rw1, 0);
        check("t1_w15", i_line[15*32 +: 32], 32'hA500_002F);

        // store then read-back of the same line
        s0 = store_cnt;
        txn(1'b1, 1'b1, 32'h7, 32'hDEADBEEF, 0, lat, a1, w1, h1, rw1, rw2);
        check("t2_lat", lat, 3);
        check("t2_addr", a1, 32'h7);
        check("t2_din", w1, 32'hDEADBEEF);
        check("t2_rw1", rw1, 1);
        check("t2_rw2", rw2, 0);
        check("t2_hit", h1, 1);
        check("t2_stores", store_cnt - s0, 1);
        txn(1'b1, 1'b0, 32'h0, 32'h0, 0, lat, a1, w1, h1, rw1, rw2);
        check("t2_rd_lat", lat, 2 + RL);
        check("t2_word7", d_line[7*32 +: 32], 32'hDEADBEEF);
        check("t2_iline_held", i_line[31:0], 32'hA500_0020);

        // simultaneous requests, each dropped on its own ack
`ifdef MEM_ARB_RR_EN
        first = ~last_d_tb;
`else
        first = 1'b1;
`endif
        push_rd(first, first ? 32'h50 : 32'h40);
        push_rd(~first, first ? 32'h40 : 32'h50);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        ca[0] = -1; ca[1] = -1; n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (i_ack || d_ack) begin
                if (n < 2) ca[n] = c;
                n++;
            end
            if (i_ack) i_req = 1'b0;
            if (d_ack) d_req = 1'b0;
            if (!i_req && !d_req) break;
        end
        i_req = 1'b0; d_req = 1'b0;
        last_d_tb = ~first;
        check("t3_ack1", ca[0], 2 + RL);
        check("t3_ack2", ca[1], 5 + 2 * RL);

        // back-to-back stores with d_req held
        push_wr(32'h30, 32'h1111_1111);
        push_wr(32'h31, 32'h2222_2222);
        s0 = store_cnt;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h1111_1111;
        ca[0] = -1; ca[1] = -1; n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_ack) begin
                if (n < 2) ca[n] = c;
                n++;
                d_addr = 32'h31; d_wdata = 32'h2222_2222;
                if (n >= 2) break;
            end
        end
        d_req = 1'b0; d_we = 1'b0;
        last_d_tb = 1'b1;
        check("t4_ack1", ca[0], 3);
        check("t4_ack2", ca[1], 7);
        check("t4_stores", store_cnt - s0, 2);
        check("t4_mem30", mem[8'h30], 32'h1111_1111);
        check("t4_mem31", mem[8'h31], 32'h2222_2222);

        // memory busy for 4 cycles during issue
        txn(1'b1, 1'b0, 32'h80, 32'h0, 4, lat, a1, w1, h1, rw1, rw2);
        check("t5_lat", lat, 2 + RL + 4);
        check("t5_addr", a1, 32'h80);
        check("t5_hit", h1, 0);

        // reset while waiting for read data
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h60;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        check("t6_pre_hit", mem_hit, 0);
        reset = 1'b1; i_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset("t6");
        reset = 1'b0;
        last_d_tb = 1'b1;
        txn(1'b0, 1'b0, 32'h25, 32'h0, 0, lat, a1, w1, h1, rw1, rw2);
        check("t6_after_lat", lat, 2 + RL);
        check("t6_after_addr", a1, 32'h20);

        repeat (3) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
